// File: rtl/slv_abort_responder_pkg.sv
// Shared types for the subordinate abort responder: FSM states, the SLVERR
// code and a compact AXI channel/request/response struct set.
package slv_abort_pkg;

    localparam int unsigned ID_W   = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } state_e;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [7:0] len_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        len_t              len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
        logic            user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic              user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

// File: rtl/slv_abort_responder_fifo.sv
// Minimal fifo_v3-compatible queue with synchronous active-low reset; used
// to remember the burst length of each outstanding read per ID.
module fifo_v3 #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    dtype              mem_r [DEPTH];
    logic [AddrW-1:0]  rd_ptr_r;
    logic [AddrW-1:0]  wr_ptr_r;
    logic [CntW-1:0]   cnt_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
        return (ptr == AddrW'(DEPTH - 1)) ? '0 : ptr + AddrW'(1);
    endfunction

    assign full_o    = (cnt_r == CntW'(DEPTH));
    assign empty_o   = (cnt_r == '0);
    assign data_o    = mem_r[rd_ptr_r];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CntW'(1);
                2'b01:   cnt_r <= cnt_r - CntW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/slv_abort_responder.sv
// Transparent AXI stage that tracks outstanding transactions per internal ID
// and, on abort, isolates the subordinate and completes them with SLVERR.
import slv_abort_pkg::*;

module slv_abort_responder #(
    parameter int unsigned IntIdWidth   = 2,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter type         req_t        = axi_req_t,
    parameter type         rsp_t        = axi_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t mst_req_i,
    output rsp_t mst_rsp_o,
    output req_t slv_req_o,
    input  rsp_t slv_rsp_i,
    input  logic abort_i,
    input  logic clear_i,
    output logic busy_o,
    output logic drained_o
);

    localparam int unsigned NumIds = 2 ** IntIdWidth;
    localparam int unsigned CntW   = $clog2(MaxTxnsPerId + 1);
    localparam int unsigned DebtW  = $clog2(NumIds * MaxTxnsPerId * 256 + 1);

    typedef logic [IntIdWidth-1:0] id_t;
    typedef logic [CntW-1:0]       cnt_t;
    typedef logic [DebtW-1:0]      debt_t;

    state_e            state_r, state_s;
    cnt_t              wr_cnt_r  [NumIds];
    cnt_t              wr_cnt_s  [NumIds];
    len_t              rd_sent_r [NumIds];
    len_t              rd_sent_s [NumIds];
    debt_t             wdebt_r, wdebt_s, debt_sum_s;
    logic [NumIds-1:0] fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    len_t              fifo_head_s [NumIds];
    logic              aw_full_s, ar_full_s, busy_s;
    logic              b_sel_vld_s, r_sel_vld_s;
    id_t               b_sel_id_s, r_sel_id_s;
    logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    for (genvar g = 0; g < NumIds; g++) begin : g_rd_fifo
        fifo_v3 #(
            .DEPTH (MaxTxnsPerId),
            .dtype (len_t)
        ) i_len_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .full_o  (fifo_full_s[g]),
            .empty_o (fifo_empty_s[g]),
            .data_i  (mst_req_i.ar.len),
            .push_i  (fifo_push_s[g]),
            .data_o  (fifo_head_s[g]),
            .pop_i   (fifo_pop_s[g])
        );
    end

    // Lowest-ID pickers for generated B and R; the choice cannot change until
    // its own completion since no new transactions enter outside PASS.
    always_comb begin
        b_sel_vld_s = 1'b0;
        b_sel_id_s  = '0;
        r_sel_vld_s = 1'b0;
        r_sel_id_s  = '0;
        busy_s      = (wdebt_r != '0);
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (wr_cnt_r[i] != '0) begin
                b_sel_vld_s = 1'b1;
                b_sel_id_s  = id_t'(i);
                busy_s      = 1'b1;
            end else begin
                b_sel_vld_s = b_sel_vld_s;
            end
            if (!fifo_empty_s[i]) begin
                r_sel_vld_s = 1'b1;
                r_sel_id_s  = id_t'(i);
                busy_s      = 1'b1;
            end else begin
                r_sel_vld_s = r_sel_vld_s;
            end
        end
    end

    assign aw_full_s = (wr_cnt_r[mst_req_i.aw.id] == cnt_t'(MaxTxnsPerId));
    assign ar_full_s = fifo_full_s[mst_req_i.ar.id];

    // Datapath muxing for the three operating states.
    always_comb begin
        slv_req_o = '0;
        mst_rsp_o = '0;
        case (state_r)
            PASS: begin
                slv_req_o          = mst_req_i;
                mst_rsp_o          = slv_rsp_i;
                slv_req_o.aw_valid = mst_req_i.aw_valid & ~aw_full_s;
                mst_rsp_o.aw_ready = slv_rsp_i.aw_ready & ~aw_full_s;
                slv_req_o.ar_valid = mst_req_i.ar_valid & ~ar_full_s;
                mst_rsp_o.ar_ready = slv_rsp_i.ar_ready & ~ar_full_s;
            end
            DRAIN: begin
                slv_req_o.b_ready = 1'b1;
                slv_req_o.r_ready = 1'b1;
                mst_rsp_o.w_ready = (wdebt_r != '0);
                mst_rsp_o.b_valid = b_sel_vld_s;
                mst_rsp_o.b.id    = b_sel_id_s;
                mst_rsp_o.b.resp  = RESP_SLVERR;
                mst_rsp_o.r_valid = r_sel_vld_s;
                mst_rsp_o.r.id    = r_sel_id_s;
                mst_rsp_o.r.resp  = RESP_SLVERR;
                mst_rsp_o.r.last  = (rd_sent_r[r_sel_id_s] == fifo_head_s[r_sel_id_s]);
            end
            ISOLATED: begin
                slv_req_o.b_ready = 1'b1;
                slv_req_o.r_ready = 1'b1;
            end
            default: begin
                slv_req_o = '0;
                mst_rsp_o = '0;
            end
        endcase
    end

    assign aw_hs_s = mst_req_i.aw_valid & mst_rsp_o.aw_ready;
    assign w_hs_s  = mst_req_i.w_valid  & mst_rsp_o.w_ready;
    assign b_hs_s  = mst_rsp_o.b_valid  & mst_req_i.b_ready;
    assign ar_hs_s = mst_req_i.ar_valid & mst_rsp_o.ar_ready;
    assign r_hs_s  = mst_rsp_o.r_valid  & mst_req_i.r_ready;

    // Outstanding-transaction bookkeeping from manager-side handshakes.
    always_comb begin
        fifo_push_s = '0;
        fifo_pop_s  = '0;
        for (int i = 0; i < int'(NumIds); i++) begin
            wr_cnt_s[i]  = wr_cnt_r[i];
            rd_sent_s[i] = rd_sent_r[i];
            case ({aw_hs_s && (mst_req_i.aw.id == id_t'(i)),
                   b_hs_s && (mst_rsp_o.b.id == id_t'(i)) && (wr_cnt_r[i] != '0)})
                2'b10:   wr_cnt_s[i] = wr_cnt_r[i] + cnt_t'(1);
                2'b01:   wr_cnt_s[i] = wr_cnt_r[i] - cnt_t'(1);
                default: wr_cnt_s[i] = wr_cnt_r[i];
            endcase
            if (r_hs_s && (mst_rsp_o.r.id == id_t'(i))) begin
                rd_sent_s[i]  = mst_rsp_o.r.last ? '0 : rd_sent_r[i] + 8'd1;
                fifo_pop_s[i] = mst_rsp_o.r.last & ~fifo_empty_s[i];
            end else begin
                rd_sent_s[i] = rd_sent_r[i];
            end
            fifo_push_s[i] = ar_hs_s && (mst_req_i.ar.id == id_t'(i));
        end
        debt_sum_s = wdebt_r + (aw_hs_s ? debt_t'(mst_req_i.aw.len) + debt_t'(1) : '0);
        // W ahead of its AW may pass through; the debt floors at zero.
        if (w_hs_s && (debt_sum_s != '0)) begin
            wdebt_s = debt_sum_s - debt_t'(1);
        end else begin
            wdebt_s = debt_sum_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            PASS:     state_s = abort_i ? DRAIN : PASS;
            DRAIN:    state_s = busy_s ? DRAIN : ISOLATED;
            ISOLATED: state_s = clear_i ? PASS : ISOLATED;
            default:  state_s = PASS;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= PASS;
            wdebt_r <= '0;
            for (int i = 0; i < int'(NumIds); i++) begin
                wr_cnt_r[i]  <= '0;
                rd_sent_r[i] <= '0;
            end
        end else begin
            state_r <= state_s;
            wdebt_r <= wdebt_s;
            for (int i = 0; i < int'(NumIds); i++) begin
                wr_cnt_r[i]  <= wr_cnt_s[i];
                rd_sent_r[i] <= rd_sent_s[i];
            end
        end
    end

    assign busy_o    = busy_s;
    assign drained_o = (state_r == ISOLATED);

endmodule

// File: tb/tb_slv_abort_responder.sv
// Directed bench for slv_abort_responder: pass-through, write/read abort,
// B ordering, per-ID read limit, reset and clear.
import slv_abort_pkg::*;

module tb_slv_abort_responder;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     abort, clear;
    logic     busy, drained;
    axi_req_t mst_req, slv_req;
    axi_rsp_t mst_rsp, slv_rsp;
    int       n_cmp = 0;
    int       n_err = 0;

    always #5 clk = ~clk;

    slv_abort_responder #(
        .IntIdWidth   (2),
        .MaxTxnsPerId (4),
        .req_t        (axi_req_t),
        .rsp_t        (axi_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mst_req_i (mst_req),
        .mst_rsp_o (mst_rsp),
        .slv_req_o (slv_req),
        .slv_rsp_i (slv_rsp),
        .abort_i   (abort),
        .clear_i   (clear),
        .busy_o    (busy),
        .drained_o (drained)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        mst_req          = '0;
        slv_rsp          = '0;
        slv_rsp.aw_ready = 1'b1;
        slv_rsp.w_ready  = 1'b1;
        slv_rsp.ar_ready = 1'b1;
    endtask

    task automatic send_aw(input logic [1:0] id, input logic [7:0] len);
        mst_req.aw_valid = 1'b1;
        mst_req.aw.id    = id;
        mst_req.aw.len   = len;
        tick();
        mst_req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [1:0] id, input logic [7:0] len);
        mst_req.ar_valid = 1'b1;
        mst_req.ar.id    = id;
        mst_req.ar.len   = len;
        tick();
        mst_req.ar_valid = 1'b0;
    endtask

    task automatic send_w(input int n);
        mst_req.w_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            mst_req.w.data = 32'hA000_0000 + 32'(i);
            tick();
        end
        mst_req.w_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        abort = 1'b0;
        clear = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_drained", 64'(drained), 64'd0);

        // PASS write, fully transparent
        mst_req.aw_valid = 1'b1;
        mst_req.aw.id    = 2'd1;
        mst_req.aw.len   = 8'd3;
        mst_req.aw.addr  = 32'h0000_1230;
        settle();
        check_val("pass_aw_valid", 64'(slv_req.aw_valid), 64'd1);
        check_val("pass_aw_addr", 64'(slv_req.aw.addr), 64'h1230);
        check_val("pass_aw_ready", 64'(mst_rsp.aw_ready), 64'd1);
        tick();
        mst_req.aw_valid = 1'b0;
        check_val("pass_busy_aw", 64'(busy), 64'd1);
        mst_req.w_valid = 1'b1;
        mst_req.w.data  = 32'hDEAD_BEEF;
        settle();
        check_val("pass_w_data", 64'(slv_req.w.data), 64'hDEAD_BEEF);
        mst_req.w_valid = 1'b0;
        send_w(4);
        slv_rsp.b_valid = 1'b1;
        slv_rsp.b.id    = 2'd1;
        slv_rsp.b.resp  = 2'b00;
        mst_req.b_ready = 1'b1;
        settle();
        check_val("pass_b", 64'({mst_rsp.b_valid, mst_rsp.b.id, mst_rsp.b.resp}), 64'b1_01_00);
        tick();
        slv_rsp.b_valid = 1'b0;
        mst_req.b_ready = 1'b0;
        check_val("pass_idle_busy", 64'(busy), 64'd0);

        // Write abort with owed W beats
        send_aw(2'd0, 8'd7);
        send_w(2);
        do_abort();
        mst_req.aw_valid = 1'b1;
        mst_req.w_valid  = 1'b1;
        settle();
        check_val("drain_slv_aw_valid", 64'(slv_req.aw_valid), 64'd0);
        check_val("drain_mst_aw_ready", 64'(mst_rsp.aw_ready), 64'd0);
        check_val("drain_slv_w_valid", 64'(slv_req.w_valid), 64'd0);
        check_val("drain_slv_b_ready", 64'(slv_req.b_ready), 64'd1);
        mst_req.aw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_val("drain_w_ready", 64'(mst_rsp.w_ready), 64'd1);
            tick();
        end
        check_val("drain_w_stall", 64'(mst_rsp.w_ready), 64'd0);
        mst_req.w_valid = 1'b0;
        check_val("drain_b", 64'({mst_rsp.b_valid, mst_rsp.b.id, mst_rsp.b.resp}), 64'b1_00_10);
        mst_req.b_ready = 1'b1;
        tick();
        mst_req.b_ready = 1'b0;
        check_val("drain_not_yet_iso", 64'(drained), 64'd0);
        check_val("drain_busy_clear", 64'(busy), 64'd0);
        tick();
        check_val("iso_drained", 64'(drained), 64'd1);
        mst_req.aw_valid = 1'b1;
        settle();
        check_val("iso_aw_ready", 64'(mst_rsp.aw_ready), 64'd0);
        mst_req.aw_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("iso_abort_ignored", 64'(drained), 64'd1);
        do_clear();
        check_val("clear_drained", 64'(drained), 64'd0);
        mst_req.aw_valid = 1'b1;
        mst_req.aw.id    = 2'd2;
        mst_req.aw.len   = 8'd0;
        settle();
        check_val("clear_aw_pass", 64'({slv_req.aw_valid, mst_rsp.aw_ready}), 64'b11);
        mst_req.aw_valid = 1'b0;

        // Read abort mid-burst
        send_ar(2'd2, 8'd3);
        send_ar(2'd2, 8'd0);
        slv_rsp.r_valid = 1'b1;
        slv_rsp.r.id    = 2'd2;
        slv_rsp.r.data  = 32'h1234_5678;
        mst_req.r_ready = 1'b1;
        settle();
        check_val("pass_r_data", 64'(mst_rsp.r.data), 64'h1234_5678);
        tick();
        mst_req.r_ready = 1'b0;
        do_abort();
        check_val("rdrain_slv_r_ready", 64'(slv_req.r_ready), 64'd1);
        check_val("rdrain_hold", 64'({mst_rsp.r_valid, mst_rsp.r.id, mst_rsp.r.resp, mst_rsp.r.last}),
                  64'b1_10_10_0);
        mst_req.r_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_val("rdrain_beat", 64'({mst_rsp.r_valid, mst_rsp.r.resp, mst_rsp.r.last}),
                      64'({1'b1, 2'b10, (i == 2)}));
            check_val("rdrain_data", 64'(mst_rsp.r.data), 64'd0);
            tick();
        end
        check_val("rdrain_single", 64'({mst_rsp.r_valid, mst_rsp.r.id, mst_rsp.r.last}), 64'b1_10_1);
        tick();
        slv_rsp.r_valid = 1'b0;
        mst_req.r_ready = 1'b0;
        check_val("rdrain_r_done", 64'(mst_rsp.r_valid), 64'd0);
        tick();
        check_val("rdrain_iso", 64'(drained), 64'd1);
        do_clear();

        // B ordering and stability under back-pressure
        send_aw(2'd3, 8'd0);
        send_aw(2'd0, 8'd0);
        send_aw(2'd1, 8'd0);
        send_w(3);
        do_abort();
        for (int i = 0; i < 5; i++) begin
            settle();
            check_val("b_hold", 64'({mst_rsp.b_valid, mst_rsp.b.id}), 64'b1_00);
            tick();
        end
        mst_req.b_ready = 1'b1;
        settle();
        check_val("b_order0", 64'({mst_rsp.b_valid, mst_rsp.b.id}), 64'b1_00);
        tick();
        check_val("b_order1", 64'({mst_rsp.b_valid, mst_rsp.b.id}), 64'b1_01);
        tick();
        check_val("b_order3", 64'({mst_rsp.b_valid, mst_rsp.b.id}), 64'b1_11);
        tick();
        mst_req.b_ready = 1'b0;
        check_val("b_done", 64'(mst_rsp.b_valid), 64'd0);
        tick();
        check_val("b_iso", 64'(drained), 64'd1);
        do_clear();

        // Read limit per ID
        for (int i = 0; i < 4; i++) begin
            send_ar(2'd1, 8'd0);
        end
        mst_req.ar_valid = 1'b1;
        mst_req.ar.id    = 2'd1;
        settle();
        check_val("full_ar_ready", 64'({mst_rsp.ar_ready, slv_req.ar_valid}), 64'b00);
        slv_rsp.r_valid = 1'b1;
        slv_rsp.r.id    = 2'd1;
        slv_rsp.r.last  = 1'b1;
        mst_req.r_ready = 1'b1;
        mst_req.ar_valid = 1'b0;
        settle();
        mst_req.ar_valid = 1'b1;
        settle();
        check_val("full_same_cycle", 64'(mst_rsp.ar_ready), 64'd0);
        mst_req.ar_valid = 1'b0;
        tick();
        mst_req.ar_valid = 1'b1;
        settle();
        check_val("full_released", 64'({mst_rsp.ar_ready, slv_req.ar_valid}), 64'b11);
        tick();
        mst_req.ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        slv_rsp.r_valid = 1'b0;
        mst_req.r_ready = 1'b0;
        check_val("full_idle", 64'(busy), 64'd0);

        // Reset in the middle of DRAIN
        send_aw(2'd0, 8'd0);
        do_abort();
        check_val("rst_mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check_val("rst_mid_busy_after", 64'(busy), 64'd0);
        check_val("rst_mid_drained", 64'(drained), 64'd0);
        mst_req.aw_valid = 1'b1;
        settle();
        check_val("rst_mid_pass", 64'({slv_req.aw_valid, mst_rsp.aw_ready}), 64'b11);
        mst_req.aw_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
